uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Receive buffer directly downstream of the UART receiver.
//  - Captures each byte on the receiver's one-cycle data-valid strobe into a first-word-fall-through FIFO.
//  - Gives the CPU/bus side a pop handshake, fill level, sticky overflow flag and level-triggered interrupt.
//  - Decouples byte arrival, one per ~10*CLKS_PER_BIT cycles, from irregular software polling.
// PARAMETERS
//  DEPTH      16  FIFO entries; power of two, >= 2
//  IRQ_LEVEL  1   o_Irq asserts when o_Count >= IRQ_LEVEL; range 1..DEPTH
//  AW         $clog2(DEPTH)  pointer width (localparam, not overridable)
// PORTS
//  i_Clock     in   1     system clock, all logic on rising edge
//  i_Reset_n   in   1     asynchronous active-low reset
//  i_Rx_DV     in   1     one-cycle strobe from UART receiver: i_Rx_Byte valid
//  i_Rx_Byte   in   8     received byte
//  i_Rd        in   1     pop head entry; sampled on rising edge
//  i_Clr_Ovf   in   1     clear sticky overflow flag
//  o_Data      out  8     head-of-FIFO byte; valid while o_Empty=0
//  o_Empty     out  1     FIFO holds no entries
//  o_Full      out  1     FIFO holds DEPTH entries
//  o_Count     out  AW+1  number of stored entries, 0..DEPTH
//  o_Overflow  out  1     sticky: a byte was dropped because FIFO was full
//  o_Irq       out  1     level interrupt, o_Count >= IRQ_LEVEL
// BEHAVIOUR
//  Reset values (async on i_Reset_n=0, any time, including mid-operation):
//   - wr_ptr=rd_ptr=0, o_Count=0, o_Empty=1, o_Full=0, o_Overflow=0, o_Irq=0.
//   - Storage array is not reset; o_Data is don't-care while o_Empty=1.
//  Storage: DEPTH x 8 register array; pointers AW bits, wrap DEPTH-1 -> 0 naturally.
//  Count register: AW+1 bits, authoritative.
//   - o_Empty = (count==0), o_Full = (count==DEPTH), o_Irq = (count>=IRQ_LEVEL).
//   - All three are decoded from registered count only; no input-to-output combinational path.
//  Push: i_Rx_DV=1 and (count<DEPTH or pop accepted same cycle).
//   - mem[wr_ptr]<=i_Rx_Byte, wr_ptr++.
//  Pop: i_Rd=1 and count>0.
//   - rd_ptr++.
//   - i_Rd while empty is ignored; no pointer or flag change.
//  Count update: +1 push only, -1 pop only, unchanged on push+pop or neither.
//  Latency:
//   - Byte strobed at edge N appears on o_Data with o_Empty=0 after edge N (next cycle) when FIFO was empty.
//   - o_Data = mem[rd_ptr], combinational read of the registered array (FWFT).
//   - After an accepted pop at edge N, o_Data shows the next entry from edge N on.
//  Full boundary:
//   - Push+pop in same cycle while full: both accepted, count stays DEPTH, no overflow.
//   - Push while full without pop: byte dropped, pointers unchanged, o_Overflow<=1.
//  Empty boundary: push+pop in same cycle while empty: pop ignored, push accepted, count becomes 1.
//  Overflow flag:
//   - Set wins over clear when i_Clr_Ovf and a dropping push coincide.
//   - Otherwise i_Clr_Ovf clears it next edge.
//   - Has no effect on FIFO contents.
//  i_Rx_DV is assumed single-cycle per byte; back-to-back strobes are each treated as a separate push.
// TESTING
//  1 Reset: assert i_Reset_n=0 mid-stream with count=5 -> outputs immediately Empty=1, Count=0, Ovf=0, Irq=0.
//  2 Single byte: strobe 0xA5 on empty FIFO -> next cycle o_Data=0xA5, Empty=0, Count=1, Irq=1; pulse i_Rd -> Empty=1.
//  3 Fill/order: push 0x00..0x0F (DEPTH=16) -> Full=1, Count=16; 16 pops return 0x00..0x0F in order across pointer wrap.
//  4 Overflow: with FIFO full, strobe 0x55 -> Ovf=1, Count=16, head unchanged. Pop all -> 0x55 never seen. i_Clr_Ovf -> Ovf=0.
//  5 Simultaneous: full + push 0x77 + pop same cycle -> Count=16, Ovf=0, 0x77 last out. Empty + push 0x33 + pop -> Count=1, o_Data=0x33.
//  6 Irq threshold: IRQ_LEVEL=4 -> Irq low at counts 0..3, high at 4. Pop to 3 -> Irq low next cycle. Pop when empty -> no change.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer between the UART receiver and the bus side.
// Provides a pop handshake, fill level, sticky overflow flag and a level-triggered interrupt.
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int IRQ_LEVEL = 1
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset_n,
  input  logic                       i_Rx_DV,
  input  logic [7:0]                 i_Rx_Byte,
  input  logic                       i_Rd,
  input  logic                       i_Clr_Ovf,
  output logic [7:0]                 o_Data,
  output logic                       o_Empty,
  output logic                       o_Full,
  output logic [$clog2(DEPTH):0]     o_Count,
  output logic                       o_Overflow,
  output logic                       o_Irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] IRQ_CNT  = (AW+1)'(IRQ_LEVEL);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          overflow;
  logic          do_push;
  logic          do_pop;
  logic          drop;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign do_pop  = i_Rd && (count != '0);
  assign do_push = i_Rx_DV && ((count != FULL_CNT) || do_pop);
  assign drop    = i_Rx_DV && !do_push;

  always_ff @(posedge i_Clock) begin
    if (do_push) begin
      mem[wr_ptr] <= i_Rx_Byte;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Set takes priority over clear so a coincident drop is never lost.
      if (drop) begin
        overflow <= 1'b1;
      end else if (i_Clr_Ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  assign o_Data     = mem[rd_ptr];
  assign o_Count    = count;
  assign o_Empty    = (count == '0);
  assign o_Full     = (count == FULL_CNT);
  assign o_Irq      = (count >= IRQ_CNT);
  assign o_Overflow = overflow;

endmodule
